// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the multi-channel clock controller: channel modes
// and the per-channel FSM state encoding.
package clock_ctrl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HALT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_STOPPING = 3'd1;
  localparam logic [2:0] ST_HALTED   = 3'd2;
  localparam logic [2:0] ST_STEP_LO  = 3'd3;
  localparam logic [2:0] ST_STEP_HI  = 3'd4;

endpackage

// File: rtl/clock_ctrl_chan.sv
// One divided-clock channel: half-period counter, run/stop/step FSM,
// shadowed half-period register and rising-edge counter.
module clock_ctrl_chan
  import clock_ctrl_pkg::*;
#(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = '1,
  parameter int               EDGE_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [CNT_W-1:0]  cfg_half_i,
  input  logic              step_i,
  output logic              out_clk_o,
  output logic              rise_pulse_o,
  output logic              halted_o,
  output logic [EDGE_W-1:0] edges_o,
  output logic [2:0]        state_o
);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  active_q, active_d;
  logic [CNT_W-1:0]  shadow_q;
  logic [1:0]        mode_q;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic [EDGE_W-1:0] edges_q, edges_d;
  logic              hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    out_d    = out_q;
    rise_d   = 1'b0;
    edges_d  = edges_q;
    hit      = (cnt_q == active_q);
    case (state_q)
      ST_RUN, ST_STOPPING: begin
        if (state_q == ST_RUN && mode_q != MODE_RUN && !out_q) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end else if (hit) begin
          cnt_d    = '0;
          out_d    = !out_q;
          active_d = shadow_q;
          // Any pending stop is only honoured here, so the falling toggle parks the output.
          if (state_q == ST_STOPPING || mode_q != MODE_RUN) begin
            state_d = ST_HALTED;
          end else if (!out_q) begin
            rise_d  = 1'b1;
            edges_d = edges_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mode_q != MODE_RUN) state_d = ST_STOPPING;
        end
      end
      ST_HALTED: begin
        cnt_d = '0;
        case (mode_q)
          MODE_RUN:  state_d = ST_RUN;
          MODE_STEP: begin
            if (step_i) begin
              state_d  = ST_STEP_LO;
              active_d = shadow_q;
            end
          end
          MODE_HALT, MODE_RSVD: state_d = ST_HALTED;
          default:              state_d = ST_HALTED;
        endcase
      end
      ST_STEP_LO: begin
        if (hit) begin
          cnt_d    = '0;
          out_d    = 1'b1;
          rise_d   = 1'b1;
          edges_d  = edges_q + 1'b1;
          active_d = shadow_q;
          state_d  = ST_STEP_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STEP_HI: begin
        if (hit) begin
          cnt_d    = '0;
          out_d    = 1'b0;
          active_d = shadow_q;
          state_d  = ST_HALTED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_HALTED;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      active_q <= DEFAULT_HALF;
      shadow_q <= DEFAULT_HALF;
      mode_q   <= MODE_RUN;
      out_q    <= 1'b0;
      rise_q   <= 1'b0;
      edges_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      edges_q  <= edges_d;
      if (cfg_we_i) begin
        mode_q   <= cfg_mode_i;
        shadow_q <= cfg_half_i;
      end
    end
  end

  assign out_clk_o    = out_q;
  assign rise_pulse_o = rise_q;
  assign halted_o     = (state_q == ST_HALTED);
  assign edges_o      = edges_q;
  assign state_o      = state_q;

endmodule

// File: rtl/clock_ctrl.sv
// Multi-channel clock controller: routes config writes to the addressed
// channel and concatenates the per-channel outputs.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int               CHANNELS     = 2,
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 24'h3FFFFF,
  parameter int               EDGE_W       = 32,
  localparam int              SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       hwclk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [1:0]                 cfg_mode,
  input  logic [CNT_W-1:0]           cfg_half,
  input  logic [CHANNELS-1:0]        step,
  output logic [CHANNELS-1:0]        out_clk,
  output logic [CHANNELS-1:0]        rise_pulse,
  output logic [CHANNELS-1:0]        halted,
  output logic [CHANNELS*EDGE_W-1:0] edges,
  output logic [CHANNELS*3-1:0]      state_dbg
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic we;
    // Selects at or beyond CHANNELS match no channel and are dropped.
    assign we = cfg_we && (cfg_sel == SEL_W'(g));

    clock_ctrl_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF),
      .EDGE_W      (EDGE_W)
    ) u_chan (
      .clk_i       (hwclk),
      .rst_ni      (rst_n),
      .cfg_we_i    (we),
      .cfg_mode_i  (cfg_mode),
      .cfg_half_i  (cfg_half),
      .step_i      (step[g]),
      .out_clk_o   (out_clk[g]),
      .rise_pulse_o(rise_pulse[g]),
      .halted_o    (halted[g]),
      .edges_o     (edges[g*EDGE_W +: EDGE_W]),
      .state_o     (state_dbg[g*3 +: 3])
    );
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Randomized bench for clock_ctrl: a deadline-based reference model predicts
// every channel output each cycle; directed phases cover the key scenarios.
`timescale 1ns/1ps
module tb_clock_ctrl;
  localparam int CH     = 2;
  localparam int CNT_W  = 24;
  localparam int EDGE_W = 8;
  localparam int DEF    = 3;
  localparam int SEL_W  = 1;

  logic                 hwclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [SEL_W-1:0]     cfg_sel = '0;
  logic [1:0]           cfg_mode = '0;
  logic [CNT_W-1:0]     cfg_half = '0;
  logic [CH-1:0]        step = '0;
  logic [CH-1:0]        out_clk, rise_pulse, halted;
  logic [CH*EDGE_W-1:0] edges;
  logic [CH*3-1:0]      state_dbg;

  int    n_checks = 0;
  int    n_err    = 0;
  longint cyc     = 0;
  bit    live     = 1'b0;

  // Reference model: each channel keeps the absolute cycle of its next toggle.
  bit     m_out[CH], m_rise[CH], m_parked[CH], m_stop[CH];
  int     m_step_left[CH], m_mode[CH], m_half[CH], m_sh[CH], m_edges[CH];
  longint m_next[CH];

  clock_ctrl #(
    .CHANNELS    (CH),
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(CNT_W'(DEF)),
    .EDGE_W      (EDGE_W)
  ) dut (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .step      (step),
    .out_clk   (out_clk),
    .rise_pulse(rise_pulse),
    .halted    (halted),
    .edges     (edges),
    .state_dbg (state_dbg)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_out[c] = 0; m_rise[c] = 0; m_parked[c] = 0; m_stop[c] = 0;
      m_step_left[c] = 0; m_mode[c] = 0; m_half[c] = DEF; m_sh[c] = DEF;
      m_edges[c] = 0;
      m_next[c] = cyc + 1 + DEF;
    end
  endtask

  task automatic model_toggle(input int c);
    m_out[c]  = !m_out[c];
    m_half[c] = m_sh[c];
    if (m_out[c]) begin
      m_rise[c]  = 1;
      m_edges[c] = (m_edges[c] + 1) % (1 << EDGE_W);
    end
  endtask

  task automatic model_step(input longint t);
    for (int c = 0; c < CH; c++) begin
      m_rise[c] = 0;
      if (m_parked[c]) begin
        if (m_mode[c] == 0) begin
          m_parked[c] = 0;
          m_next[c] = t + m_half[c] + 1;
        end else if (m_mode[c] == 2 && step[c]) begin
          m_half[c] = m_sh[c];
          m_step_left[c] = 2;
          m_parked[c] = 0;
          m_next[c] = t + m_half[c] + 1;
        end
      end else if (m_step_left[c] > 0) begin
        if (t == m_next[c]) begin
          model_toggle(c);
          m_step_left[c]--;
          if (m_step_left[c] == 0) m_parked[c] = 1;
          else m_next[c] = t + m_half[c] + 1;
        end
      end else if (!m_stop[c] && m_mode[c] != 0 && !m_out[c]) begin
        m_parked[c] = 1;
      end else begin
        if (m_mode[c] != 0) m_stop[c] = 1;
        if (t == m_next[c]) begin
          model_toggle(c);
          m_next[c] = t + m_half[c] + 1;
          if (m_stop[c]) begin
            m_parked[c] = 1;
            m_stop[c] = 0;
          end
        end
      end
    end
    if (cfg_we && int'(cfg_sel) < CH) begin
      m_mode[cfg_sel] = int'(cfg_mode);
      m_sh[cfg_sel]   = int'(cfg_half);
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0]        e_out, e_rise, e_halt;
    logic [CH*EDGE_W-1:0] e_edges;
    for (int c = 0; c < CH; c++) begin
      e_out[c]  = m_out[c];
      e_rise[c] = m_rise[c];
      e_halt[c] = m_parked[c];
      e_edges[c*EDGE_W +: EDGE_W] = EDGE_W'(m_edges[c]);
    end
    check("out_clk", 64'(out_clk), 64'(e_out));
    check("rise_pulse", 64'(rise_pulse), 64'(e_rise));
    check("halted", 64'(halted), 64'(e_halt));
    check("edges", 64'(edges), 64'(e_edges));
  endtask

  initial begin
    forever begin
      @(posedge hwclk);
      cyc++;
      if (live && rst_n) begin
        model_step(cyc);
        #1;
        compare_model();
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic cfg_write(input int sel, input logic [1:0] mode, input int half);
    cfg_we = 1'b1; cfg_sel = SEL_W'(sel); cfg_mode = mode; cfg_half = CNT_W'(half);
    @(negedge hwclk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_level(input int c, input logic lvl, input string tag);
    int n = 0;
    while (out_clk[c] !== lvl && n < 200) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, 64'(out_clk[c]), 64'(lvl));
  endtask

  task automatic wait_halted(input int c, input string tag);
    int n = 0;
    while (halted[c] !== 1'b1 && n < 200) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, 64'(halted[c]), 64'd1);
  endtask

  task automatic do_reset_release();
    @(negedge hwclk);
    rst_n = 1'b1;
    model_reset();
    live = 1'b1;
  endtask

  initial begin
    wait_cycles(3);
    check("rst_out_clk", 64'(out_clk), 64'd0);
    check("rst_rise", 64'(rise_pulse), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_edges", 64'(edges), 64'd0);
    do_reset_release();
    wait_cycles(20);

    // ch0 at the fastest rate, ch1 untouched
    cfg_write(0, 2'b00, 0);
    wait_cycles(20);

    // halt two cycles into a high phase of a half=3 clock
    cfg_write(0, 2'b00, 3);
    wait_cycles(4);
    wait_level(0, 1'b0, "wait_low_ch0");
    wait_level(0, 1'b1, "wait_high_ch0");
    @(negedge hwclk);
    cfg_write(0, 2'b01, 3);
    wait_halted(0, "halt_ch0");
    wait_cycles(10);

    // single step with half=1, second request mid-period is ignored
    cfg_write(0, 2'b10, 1);
    wait_cycles(3);
    step[0] = 1'b1;
    @(negedge hwclk);
    step[0] = 1'b0;
    wait_cycles(1);
    step[0] = 1'b1;
    @(negedge hwclk);
    step[0] = 1'b0;
    wait_cycles(8);
    step[0] = 1'b1;
    wait_cycles(14);
    step[0] = 1'b0;
    wait_cycles(6);

    // ch1 half change mid-level
    wait_cycles(2);
    cfg_write(1, 2'b00, 1);
    wait_cycles(20);

    // async reset while ch1 is high
    wait_level(1, 1'b1, "pre_rst_high");
    @(posedge hwclk);
    #3;
    live  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'(out_clk), 64'd0);
    check("async_rst_edges", 64'(edges), 64'd0);
    check("async_rst_rise", 64'(rise_pulse), 64'd0);
    do_reset_release();
    wait_cycles(10);

    // edge counter wrap on a fast channel
    cfg_write(0, 2'b00, 0);
    wait_cycles(540);

    // randomized config / step traffic
    for (int i = 0; i < 1500; i++) begin
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_sel  = SEL_W'($urandom_range(0, CH - 1));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_half = CNT_W'($urandom_range(0, 4));
      step     = CH'($urandom_range(0, (1 << CH) - 1));
      @(negedge hwclk);
    end
    cfg_we = 1'b0;
    step   = '0;
    wait_cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
